exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Iterative multiply/divide unit for the EXE stage, directly downstream of the ID/EXE pipeline register. It consumes the latched OperandA/OperandB/ALUControl, owns the architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. It asserts a stall to the hazard unit for the duration of a multi-cycle MULT/DIV, so IF/ID and ID/EXE hold their contents.

## Interface
Parameters:
- ITER, 32, number of iteration cycles per MULT/DIV (one bit per cycle; fixed at 32 for 32-bit operands).

Ports (one clock; reset is asynchronous and active-low):
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous active-low reset
- OperandA_IN  in  32  from ID/EXE OperandA_OUT (rs value; dividend / multiplicand)
- OperandB_IN  in  32  from ID/EXE OperandB_OUT (rt value; divisor / multiplier)
- ALUControl_IN  in  6  from ID/EXE ALUControl_OUT; encodings below
- STALL_OUT  out  1  to hazard unit; high = freeze IF/ID and ID/EXE this cycle
- Result_OUT  out  32  HI or LO for MFHI/MFLO, else 0
- ResultValid_OUT  out  1  high when Result_OUT carries MFHI/MFLO data
- HI_OUT  out  32  current HI register
- LO_OUT  out  32  current LO register

## Operation
- ALUControl encodings: MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULT=24, MULTU=25, DIV=26, DIVU=27. All other values: unit idle, outputs 0 except HI_OUT/LO_OUT.
- States: IDLE, BUSY, DONE.
- IDLE + MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops: absolute value, record result signs), clear 5-bit counter, go BUSY; STALL_OUT=1 combinationally.
- BUSY: one iteration per cycle; STALL_OUT=1. Multiply: shift-add on 64-bit product. Divide: restoring, one quotient bit per cycle into 64-bit remainder/quotient register. At counter==31: apply sign fix, write HI/LO, go DONE.
- DONE: STALL_OUT=0; ID/EXE advances at this edge; the same op still present is ignored. Always return to IDLE next cycle.
- Results: MULT/MULTU: {HI,LO}=64-bit product. DIV/DIVU: LO=quotient, HI=remainder. Signed: quotient negative iff signs differ; remainder takes dividend's sign (truncation toward zero).
- Divide by zero (either signedness): LO=32'hFFFFFFFF, HI=OperandA; still takes full latency.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- MTHI/MTLO: HI/LO <= OperandA_IN at the edge ending the cycle; IDLE only, no stall.
- MFHI/MFLO: Result_OUT=HI/LO combinationally, ResultValid_OUT=1; reflects MTHI/MTLO written at the previous edge.
- Reset (any state, including mid-BUSY): state IDLE, counter 0, HI=LO=0, internal operand/accumulator registers 0; in-flight op discarded.

## Timing
- Reset values: STALL_OUT=0, Result_OUT=0, ResultValid_OUT=0, HI_OUT=0, LO_OUT=0.
- MULT/DIV enters EXE in cycle 0: STALL_OUT high cycles 0–32 (33 cycles), HI/LO updated at the edge ending cycle 32, DONE in cycle 33 with STALL_OUT low; the next instruction enters EXE in cycle 34.
- MFHI in cycle 34 returns the new HI (no extra hazard logic).
- STALL_OUT is combinational from state and ALUControl_IN; no other output depends combinationally on STALL.
- A new MULT/DIV back-to-back after DONE starts normally in IDLE.

## Configuration
- EXE_MULDIV_DIV_EN defined: divider datapath compiled in; DIV/DIVU behave as above.
- Not defined: no divider logic; DIV/DIVU treated as unrecognized ops: no stall, HI/LO unchanged, ResultValid_OUT=0. MULT/MULTU and moves unaffected.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> STALL_OUT high exactly 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; then MFHI gives 0xFFFFFFFE with ResultValid_OUT=1.
- MULT -7×3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 after full 33-cycle stall; with EXE_MULDIV_DIV_EN undefined -> no stall, HI/LO unchanged.
- MTHI 0x12345678 then MFHI next cycle -> Result_OUT=0x12345678, no stall on either.
- Assert RESET low at cycle 10 of a MULT -> STALL_OUT=0, HI=LO=0 immediately; after release a new MULT 6×7 gives LO=42, HI=0.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative 32-bit multiply/divide unit for the EXE stage, owning the HI/LO registers
// Ports: CLOCK/RESET (async active-low); OperandA_IN/OperandB_IN/ALUControl_IN from ID/EXE;
//   STALL_OUT to hazard unit; Result_OUT/ResultValid_OUT for MFHI/MFLO; HI_OUT/LO_OUT current HI/LO.
// Optional divider datapath: define EXE_MULDIV_DIV_EN.
module exe_muldiv #(
  parameter int ITER = 32
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] OperandA_IN,
  input  logic [31:0] OperandB_IN,
  input  logic [5:0]  ALUControl_IN,
  output logic        STALL_OUT,
  output logic [31:0] Result_OUT,
  output logic        ResultValid_OUT,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, is_div_q, is_div_d;
  logic        is_mul_op, is_div_op, signed_op, start, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_fix, r_fix;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix, div_next;
  assign is_mul_op = (ALUControl_IN == OP_MULT) || (ALUControl_IN == OP_MULTU);
`ifdef EXE_MULDIV_DIV_EN
  assign is_div_op = (ALUControl_IN == OP_DIV) || (ALUControl_IN == OP_DIVU);
`else
  assign is_div_op = 1'b0;
`endif
  assign signed_op = (ALUControl_IN == OP_MULT) || (ALUControl_IN == OP_DIV);
  // Held in reset the unit is idle even if the pipeline still presents an op
  assign start     = RESET && (state_q == S_IDLE) && (is_mul_op || is_div_op);
  assign STALL_OUT = start || (state_q == S_BUSY);
  assign a_neg     = signed_op && OperandA_IN[31];
  assign b_neg     = signed_op && OperandB_IN[31];
  assign a_mag     = a_neg ? -OperandA_IN : OperandA_IN;
  assign b_mag     = b_neg ? -OperandB_IN : OperandB_IN;
  assign Result_OUT      = (ALUControl_IN == OP_MFHI) ? hi_q : (ALUControl_IN == OP_MFLO) ? lo_q : 32'd0;
  assign ResultValid_OUT = (ALUControl_IN == OP_MFHI) || (ALUControl_IN == OP_MFLO);
  assign HI_OUT = hi_q;
  assign LO_OUT = lo_q;
  // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first while the product grows from the top
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign prod_fix = neg_q ? -mul_next : mul_next;
`ifdef EXE_MULDIV_DIV_EN
  logic [32:0] div_r, div_diff;
  // Restoring divide: acc = {remainder, dividend/quotient}; bit 32 of the difference is the borrow
  assign div_r    = acc_q[63:31];
  assign div_diff = div_r - {1'b0, opb_q};
  assign div_next = div_diff[32] ? {div_r[31:0], acc_q[30:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1};
  // Divide by zero: remainder magnitude equals |dividend|, so restoring its sign returns OperandA
  assign q_fix    = dz_q ? 32'hFFFF_FFFF : neg_q ? -div_next[31:0] : div_next[31:0];
  assign r_fix    = rneg_q ? -div_next[63:32] : div_next[63:32];
`else
  assign div_next = acc_q;
  assign q_fix    = 32'd0;
  assign r_fix    = 32'd0;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        acc_d    = {32'd0, is_div_op ? a_mag : b_mag};
        opb_d    = is_div_op ? b_mag : a_mag;
        neg_d    = a_neg ^ b_neg;
        rneg_d   = a_neg;
        dz_d     = (OperandB_IN == 32'd0);
        is_div_d = is_div_op;
        cnt_d    = 5'd0;
        state_d  = S_BUSY;
      end else begin
        hi_d = (ALUControl_IN == OP_MTHI) ? OperandA_IN : hi_q;
        lo_d = (ALUControl_IN == OP_MTLO) ? OperandA_IN : lo_q;
      end
    end else if (state_q == S_BUSY) begin
      acc_d = is_div_q ? div_next : mul_next;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(ITER - 1)) begin
        {hi_d, lo_d} = is_div_q ? {r_fix, q_fix} : prod_fix;
        state_d      = S_DONE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
    end
  end
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: table-driven check of exe_muldiv plus directed move/reset sequences
module tb_exe_muldiv;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;
`ifdef EXE_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic [5:0]  ctl = '0;
  logic        stall, valid;
  logic [31:0] result, hi, lo;
  int tests = 0;
  int fails = 0;
  exe_muldiv dut (
    .CLOCK(clk), .RESET(rst_n), .OperandA_IN(opa), .OperandB_IN(opb), .ALUControl_IN(ctl),
    .STALL_OUT(stall), .Result_OUT(result), .ResultValid_OUT(valid), .HI_OUT(hi), .LO_OUT(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  // Presents an op at cycle 0 and counts stall cycles; returns at the start of the cycle after DONE
  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, output int n);
    ctl = c;
    opa = a;
    opb = b;
    n = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    ctl = 6'd0;
  endtask
  vec_t vecs[11];
  initial begin
    int n;
    logic [31:0] cur_hi, cur_lo, exp_hi, exp_lo;
    int exp_n;
    bit is_div;
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
    vecs[7]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{OP_MULT,  32'd6,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    #3;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    for (int i = 0; i < 11; i++) begin
      is_div = (vecs[i].ctl == OP_DIV) || (vecs[i].ctl == OP_DIVU);
      exp_n  = (is_div && !DIV_EN) ? 0 : 33;
      exp_hi = (is_div && !DIV_EN) ? cur_hi : vecs[i].hi;
      exp_lo = (is_div && !DIV_EN) ? cur_lo : vecs[i].lo;
      issue(vecs[i].ctl, vecs[i].a, vecs[i].b, n);
      chk($sformatf("v%0d_stall_cycles", i), 64'(n), 64'(exp_n));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(exp_hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(exp_lo));
      cur_hi = exp_hi;
      cur_lo = exp_lo;
    end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_stall_cycles", 64'(n), 64'd33);
    ctl = OP_MFHI;
    #1;
    chk("mfhi_result", 64'(result), 64'hFFFF_FFFE);
    chk("mfhi_valid", 64'(valid), 64'd1);
    chk("mfhi_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    ctl = OP_MTHI;
    opa = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    chk("mthi_valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1;
    ctl = OP_MFHI;
    opa = 32'd0;
    #1;
    chk("mthi_mfhi_result", 64'(result), 64'h1234_5678);
    chk("mthi_mfhi_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    ctl = OP_MTLO;
    opa = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    ctl = OP_MFLO;
    opa = 32'd0;
    #1;
    chk("mtlo_mflo_result", 64'(result), 64'h9ABC_DEF0);
    chk("mtlo_mflo_valid", 64'(valid), 64'd1);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
    @(posedge clk);
    #1;
    ctl = OP_MULT;
    opa = 32'd3;
    opb = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_mult_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    ctl = 6'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_MULT, 32'd6, 32'd7, n);
    chk("post_rst_stall_cycles", 64'(n), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd42);
    chk("post_rst_hi", 64'(hi), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
